// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the ALU share arbiter.
package alu_share_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   localparam int unsigned SEL_W  = 4;
   localparam int unsigned FLAG_W = 4;

   localparam logic [SEL_W-1:0] ALU_ADD   = 4'd0;
   localparam logic [SEL_W-1:0] ALU_SUB   = 4'd1;
   localparam logic [SEL_W-1:0] ALU_PASSB = 4'd3;
   localparam logic [SEL_W-1:0] ALU_OR    = 4'd4;
   localparam logic [SEL_W-1:0] ALU_AND   = 4'd5;
   localparam logic [SEL_W-1:0] ALU_XOR   = 4'd7;
   localparam logic [SEL_W-1:0] ALU_SRL   = 4'd8;
   localparam logic [SEL_W-1:0] ALU_SLL   = 4'd9;
   localparam logic [SEL_W-1:0] ALU_SRA   = 4'd10;
   localparam logic [SEL_W-1:0] ALU_SLT   = 4'd13;
   localparam logic [SEL_W-1:0] ALU_SLTU  = 4'd15;

   // Bit positions inside the {Z,V,S,C} flag nibble.
   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_V = 2;
   localparam int unsigned FLAG_S = 1;
   localparam int unsigned FLAG_C = 0;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index after `last`, wrapping.
module alu_share_arbiter_rr_pick #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IDW  = 2
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  last,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx,
   output logic            any_valid
);

   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;

   // Rotate so bit 0 is the requester right after `last`; lowest set bit wins.
   always_comb begin
      dbl       = {valid, valid};
      rot       = NREQ'(dbl >> (32'(last) + 32'd1));
      any_valid = |valid;
      grant_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            grant_idx = IDW'((32'(last) + 32'd1 + 32'(i)) % NREQ);
         end
      end
      grant = any_valid ? (NREQ'(1) << grant_idx) : '0;
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU among NREQ requesters.
// Optional grant locking is built when ALU_ARB_LOCK_EN is defined.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned W    = 32,
   parameter int unsigned IDW  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*W-1:0]   req_a,
   input  logic [NREQ*W-1:0]   req_b,
   input  logic [NREQ*4-1:0]   req_sel,
   input  logic [NREQ-1:0]     req_lock,
   output logic [W-1:0]        alu_a,
   output logic [W-1:0]        alu_b,
   output logic [SEL_W-1:0]    alu_sel,
   input  logic [W-1:0]        alu_out,
   input  logic [FLAG_W-1:0]   alu_flags,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [W-1:0]        rsp_data,
   output logic [FLAG_W-1:0]   rsp_flags
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_e        state_q, state_d;
   logic [IDW-1:0]    last_q, last_d;
   logic [W-1:0]      alu_a_d, alu_b_d, rsp_data_d;
   logic [SEL_W-1:0]  alu_sel_d;
   logic              rsp_valid_d;
   logic [IDW-1:0]    rsp_id_d;
   logic [FLAG_W-1:0] rsp_flags_d;

   logic [W-1:0]      a_arr   [NREQ];
   logic [W-1:0]      b_arr   [NREQ];
   logic [SEL_W-1:0]  sel_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign a_arr[i]   = req_a[i*W +: W];
      assign b_arr[i]   = req_b[i*W +: W];
      assign sel_arr[i] = req_sel[i*SEL_W +: SEL_W];
   end

   logic [NREQ-1:0] rr_grant;
   logic [IDW-1:0]  rr_idx;
   logic            rr_any;

   alu_share_arbiter_rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_pick (
      .valid     (req_valid),
      .last      (last_q),
      .grant     (rr_grant),
      .grant_idx (rr_idx),
      .any_valid (rr_any)
   );

   logic            lock_hit;
   logic            win_any;
   logic [IDW-1:0]  win_idx;
   logic [NREQ-1:0] win_onehot;

`ifdef ALU_ARB_LOCK_EN
   logic lock_q, lock_d;

   assign lock_hit = lock_q & req_valid[PW'(last_q)];

   // Lock follows the winner's req_lock; an idle visit with no winner drops it.
   always_comb begin
      lock_d = lock_q;
      if (state_q == ST_IDLE) begin
         lock_d = win_any ? req_lock[PW'(win_idx)] : 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) lock_q <= 1'b0;
      else     lock_q <= lock_d;
   end
`else
   logic unused_lock;
   assign unused_lock = ^req_lock;
   assign lock_hit    = 1'b0;
`endif

   assign win_any    = lock_hit | rr_any;
   assign win_idx    = lock_hit ? last_q : rr_idx;
   assign win_onehot = lock_hit ? (NREQ'(1) << last_q) : rr_grant;

   // Next-state and datapath-capture logic.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      alu_a_d     = alu_a;
      alu_b_d     = alu_b;
      alu_sel_d   = alu_sel;
      rsp_valid_d = rsp_valid;
      rsp_id_d    = rsp_id;
      rsp_data_d  = rsp_data;
      rsp_flags_d = rsp_flags;
      req_ready   = '0;
      case (state_q)
         ST_IDLE: begin
            if (win_any && !rst) begin
               req_ready = win_onehot;
               alu_a_d   = a_arr[PW'(win_idx)];
               alu_b_d   = b_arr[PW'(win_idx)];
               alu_sel_d = sel_arr[PW'(win_idx)];
               rsp_id_d  = win_idx;
               last_d    = win_idx;
               state_d   = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_data_d  = alu_out;
            rsp_flags_d = alu_flags;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         last_q    <= IDW'(NREQ - 1);
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= ALU_PASSB;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_flags <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         alu_a     <= alu_a_d;
         alu_b     <= alu_b_d;
         alu_sel   <= alu_sel_d;
         rsp_valid <= rsp_valid_d;
         rsp_id    <= rsp_id_d;
         rsp_data  <= rsp_data_d;
         rsp_flags <= rsp_flags_d;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU and arbitration model.
module tb_alu_share_arbiter;
   import alu_share_arbiter_pkg::*;

   localparam int unsigned NREQ = 2;
   localparam int unsigned W    = 32;
   localparam int unsigned IDW  = 2;
`ifdef ALU_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid, req_ready, req_lock;
   logic [NREQ*W-1:0] req_a, req_b;
   logic [NREQ*4-1:0] req_sel;
   logic [W-1:0]      alu_a, alu_b, alu_out, rsp_data;
   logic [3:0]        alu_sel, alu_flags, rsp_flags;
   logic              rsp_valid, rsp_ready;
   logic [IDW-1:0]    rsp_id;

   always #5 clk = ~clk;

   alu_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_lock(req_lock),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
      .alu_flags(alu_flags), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flags(rsp_flags)
   );

   // Behavioural ALU: returns {Z,V,S,C, result}.
   function automatic logic [W+3:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] sel);
      logic [W:0]   wide;
      logic [W-1:0] r;
      logic         v, c;
      wide = '0; r = b; v = 1'b0; c = 1'b0;
      case (sel)
         ALU_ADD: begin
            wide = {1'b0, a} + {1'b0, b}; r = wide[W-1:0]; c = wide[W];
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         ALU_SUB: begin
            wide = {1'b0, a} - {1'b0, b}; r = wide[W-1:0]; c = ~wide[W];
            v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         ALU_OR:   r = a | b;
         ALU_AND:  r = a & b;
         ALU_XOR:  r = a ^ b;
         ALU_SRL:  r = a >> b[4:0];
         ALU_SLL:  r = a << b[4:0];
         ALU_SRA:  r = W'($signed(a) >>> b[4:0]);
         ALU_SLT:  r = W'($signed(a) < $signed(b));
         ALU_SLTU: r = W'(a < b);
         default:  r = b;
      endcase
      return {(r == '0), v, r[W-1], c, r};
   endfunction

   always_comb {alu_flags, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

   typedef struct {
      int         id;
      logic [W-1:0] data;
      logic [3:0] flags;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   glog[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Requester-side stimulus state.
   logic         pend [NREQ];
   logic [W-1:0] ta [NREQ];
   logic [W-1:0] tbo [NREQ];
   logic [3:0]   ts [NREQ];
   logic         tl [NREQ];
   int unsigned  auto_pct [NREQ];
   int           left [NREQ];
   logic         lock_new [NREQ];
   int unsigned  drop_pct, rdy_pct;
   bit           rand_lock;
   logic         rst_drv;

   // Reference model: arbiter free flag, last winner, lock, response timing.
   int m_last;
   bit m_free, m_exec, m_rsp, m_lock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic new_txn(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] s, input logic l);
      pend[i] = 1'b1; ta[i] = a; tbo[i] = b; ts[i] = s; tl[i] = l;
   endtask

   function automatic logic [W-1:0] rnd_op();
      return ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
   endfunction

   task automatic gen_stim();
      for (int i = 0; i < NREQ; i++) begin
         if (pend[i] && drop_pct > 0 && $urandom_range(0, 99) < drop_pct) begin
            pend[i] = 1'b0;
         end else if (!pend[i] && left[i] != 0 && $urandom_range(0, 99) < auto_pct[i]) begin
            new_txn(i, rnd_op(), rnd_op(), 4'($urandom_range(0, 15)),
                    rand_lock ? 1'($urandom_range(0, 1)) : lock_new[i]);
            if (left[i] > 0) left[i]--;
         end
      end
      rsp_ready = ($urandom_range(0, 99) < rdy_pct);
   endtask

   task automatic apply();
      rst = rst_drv;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]        = pend[i];
         req_a[i*W +: W]     = ta[i];
         req_b[i*W +: W]     = tbo[i];
         req_sel[i*4 +: 4]   = ts[i];
         req_lock[i]         = tl[i];
      end
   endtask

   // Decide the expected winner for this cycle, compare, then advance across the edge.
   task automatic model_step();
      int g;
      int k_i;
      logic [NREQ-1:0] exp_rdy;
      logic [W+3:0] res;
      exp_t e;
      bit next_rsp;
      g = -1;
      exp_rdy = '0;
      if (!rst_drv && m_free) begin
         if (LOCK_EN && m_lock && pend[m_last]) g = m_last;
         else begin
            for (int k = 1; k <= NREQ; k++) begin
               k_i = (m_last + k) % NREQ;
               if (g < 0 && pend[k_i]) g = k_i;
            end
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) glog.push_back(i);
      if (!rst_drv) chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
      if (rst_drv) begin
         m_free = 1'b1; m_exec = 1'b0; m_rsp = 1'b0; m_lock = 1'b0;
         m_last = NREQ - 1;
         sb.delete();
      end else begin
         next_rsp = m_rsp;
         if (m_rsp && rsp_ready) begin next_rsp = 1'b0; m_free = 1'b1; end
         if (m_exec) begin next_rsp = 1'b1; m_exec = 1'b0; end
         if (m_free) m_lock = (g >= 0) ? tl[g] : 1'b0;
         if (g >= 0) begin
            res = alu_fn(ta[g], tbo[g], ts[g]);
            e.id = g; e.data = res[W-1:0]; e.flags = res[W+3:W]; e.cyc = cyc;
            sb.push_back(e);
            m_free = 1'b0; m_exec = 1'b1; m_last = g;
            pend[g] = 1'b0;
         end
         m_rsp = next_rsp;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      gen_stim();
      apply();
      #1;
      model_step();
   endtask

   task automatic do_reset();
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      rst_drv = 1'b1;
      repeat (2) cycle();
      rst_drv = 1'b0;
   endtask

   task automatic stop_auto();
      for (int i = 0; i < NREQ; i++) begin auto_pct[i] = 0; left[i] = -1; lock_new[i] = 1'b0; end
      drop_pct = 0; rand_lock = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      rdy_pct = 100;
      n = 0;
      while ((sb.size() != 0 || !m_free) && n < 20) begin cycle(); n++; end
      cycle();
      chk({name, "_drain_timeout"}, 64'(n < 20), 64'd1);
   endtask

   task automatic chk_glog(input string name, input int e0, input int e1, input int e2, input int e3);
      int exp_q[4];
      exp_q = '{e0, e1, e2, e3};
      chk({name, "_count"}, 64'(glog.size() >= 4), 64'd1);
      for (int i = 0; i < 4; i++)
         if (i < glog.size()) chk($sformatf("%s_grant%0d", name, i), 64'(glog[i]), 64'(exp_q[i]));
   endtask

   // Monitor: pops the scoreboard when a response appears and checks it stays stable.
   initial begin : monitor
      bit           holding;
      logic [IDW-1:0] h_id;
      logic [W-1:0] h_data;
      logic [3:0]   h_flags;
      exp_t         e;
      holding = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst === 1'b1) begin holding = 1'b0; continue; end
         if (rsp_valid === 1'b1) begin
            if (!holding) begin
               if (sb.size() == 0) begin
                  chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
               end else begin
                  e = sb.pop_front();
                  chk("rsp_id", 64'(rsp_id), 64'(e.id));
                  chk("rsp_data", 64'(rsp_data), 64'(e.data));
                  chk("rsp_flags", 64'(rsp_flags), 64'(e.flags));
                  chk("rsp_latency", 64'(cyc - e.cyc), 64'd2);
               end
               holding = 1'b1;
               h_id = rsp_id; h_data = rsp_data; h_flags = rsp_flags;
            end else begin
               chk("rsp_hold", {24'd0, 2'(rsp_id), rsp_data, rsp_flags}, {24'd0, 2'(h_id), h_data, h_flags});
            end
            if (rsp_ready) holding = 1'b0;
         end else if (holding) begin
            chk("rsp_dropped", 64'(rsp_valid), 64'd1);
            holding = 1'b0;
         end
      end
   end

   initial begin
      rst = 1'b1; rst_drv = 1'b1; rsp_ready = 1'b0;
      req_valid = '0; req_lock = '0; req_a = '0; req_b = '0; req_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 1'b0; ta[i] = '0; tbo[i] = '0; ts[i] = '0; tl[i] = 1'b0;
      end
      stop_auto();
      rdy_pct = 100;
      m_free = 1'b1; m_exec = 1'b0; m_rsp = 1'b0; m_lock = 1'b0; m_last = NREQ - 1;

      // Reset values.
      repeat (3) cycle();
      rst_drv = 1'b0;
      cycle();
      chk("reset_alu_a", 64'(alu_a), 64'd0);
      chk("reset_alu_b", 64'(alu_b), 64'd0);
      chk("reset_alu_sel", 64'(alu_sel), 64'h3);
      chk("reset_rsp_id", 64'(rsp_id), 64'd0);
      chk("reset_rsp_data", 64'(rsp_data), 64'd0);
      chk("reset_rsp_flags", 64'(rsp_flags), 64'd0);

      // Single op.
      glog.delete();
      new_txn(0, 32'd5, 32'd3, ALU_ADD, 1'b0);
      repeat (5) cycle();
      chk("single_grant_count", 64'(glog.size()), 64'd1);
      drain("single");

      // Fairness with both requesters always valid.
      do_reset();
      for (int i = 0; i < NREQ; i++) auto_pct[i] = 100;
      glog.delete();
      repeat (14) cycle();
      chk_glog("fair", 0, 1, 0, 1);
      stop_auto();
      drain("fair");

      // Backpressure: result held, no grants, next grant right after release.
      rdy_pct = 0;
      new_txn(0, 32'hdead_beef, 32'h1234_5678, ALU_XOR, 1'b0);
      cycle();
      new_txn(1, 32'd9, 32'd4, ALU_SUB, 1'b0);
      repeat (8) cycle();
      rdy_pct = 100;
      repeat (5) cycle();
      drain("bp");

      // Flag corner cases.
      new_txn(0, 32'd7, 32'd7, ALU_SUB, 1'b0);
      repeat (4) cycle();
      new_txn(1, 32'd1, 32'd2, ALU_SLTU, 1'b0);
      repeat (4) cycle();
      new_txn(0, 32'h7fff_ffff, 32'd1, ALU_ADD, 1'b0);
      repeat (4) cycle();
      drain("flags");

      // Reset during EXEC discards the result and restores requester 0 priority.
      do_reset();
      new_txn(1, 32'd11, 32'd22, ALU_ADD, 1'b0);
      cycle();
      rst_drv = 1'b1;
      cycle();
      rst_drv = 1'b0;
      new_txn(0, 32'd1, 32'd1, ALU_OR, 1'b0);
      new_txn(1, 32'd2, 32'd2, ALU_OR, 1'b0);
      glog.delete();
      cycle();
      chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midreset_grant_count", 64'(glog.size()), 64'd1);
      if (glog.size() > 0) chk("midreset_first_grant", 64'(glog[0]), 64'd0);
      drain("midreset");

      // Lock stimulus: requester 1 issues three locked ops while requester 0 waits.
      do_reset();
      glog.delete();
      new_txn(1, 32'd3, 32'd4, ALU_ADD, 1'b1);
      left[1] = 2; lock_new[1] = 1'b1; auto_pct[1] = 100;
      cycle();
      auto_pct[0] = 100;
      repeat (14) cycle();
      if (LOCK_EN) chk_glog("lock", 1, 1, 1, 0);
      else         chk_glog("lock", 1, 0, 1, 0);
      stop_auto();
      drain("lock");

      // Randomized traffic with drops, backpressure and lock requests.
      do_reset();
      for (int i = 0; i < NREQ; i++) auto_pct[i] = 60;
      drop_pct = 5; rdy_pct = 70; rand_lock = 1'b1;
      repeat (3000) cycle();
      stop_auto();
      drain("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
